// File: rtl/cnn_div_seq_23s_14s.sv
// Sequential restoring radix-2 signed divider (23s / 14s -> 9s saturated quotient, 14s remainder).
// One quotient bit per clock; valid/ready on both sides with a single operation in flight.
module cnn_div_seq_23s_14s #(
    parameter int DIVIDEND_W = 23,
    parameter int DIVISOR_W  = 14,
    parameter int QUOT_W     = 9
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [QUOT_W-1:0]     dout,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  ovf,
    output logic                  div_zero
);

    localparam int MW = DIVIDEND_W + 1;
    localparam int CW = $clog2(DIVIDEND_W);
    localparam int QMAX_MAG = (1 << (QUOT_W - 1)) - 1;
    localparam int QMIN_MAG = (1 << (QUOT_W - 1));
    localparam logic [QUOT_W-1:0] QMAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0] QMIN = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_n;

    logic [MW-1:0]        dvd_mag;
    logic [DIVISOR_W:0]   dvs_mag;
    logic                 neg_dvd;
    logic                 neg_q;
    logic                 dz;
    logic [CW-1:0]        cnt;
    logic [MW-1:0]        prem;
    logic [MW-1:0]        quot;

    logic signed [MW-1:0]        din0_x;
    logic signed [DIVISOR_W:0]   din1_x;
    logic [MW-1:0]               din0_mag;
    logic [DIVISOR_W:0]          din1_mag;
    logic [MW-1:0]               dvs_ext;
    logic [MW-1:0]               shl;
    logic [MW-1:0]               diff;
    logic                        ge;

    // Clamp a quotient magnitude into QUOT_W signed bits; MSB of the result is the overflow flag.
    function automatic logic [QUOT_W:0] sat_quot(input logic neg, input logic [MW-1:0] mag);
        logic [MW-1:0] lim;
        lim = neg ? MW'(QMIN_MAG) : MW'(QMAX_MAG);
        if (mag > lim)
            sat_quot = {1'b1, (neg ? QMIN : QMAX)};
        else
            sat_quot = {1'b0, QUOT_W'(neg ? (~mag + 1'b1) : mag)};
    endfunction

    // Remainder magnitude is always below |divisor|, so it fits DIVISOR_W signed bits exactly.
    function automatic logic [DIVISOR_W-1:0] sgn_rem(input logic neg, input logic [MW-1:0] mag);
        sgn_rem = DIVISOR_W'(neg ? (~mag + 1'b1) : mag);
    endfunction

    assign din0_x   = {{(MW-DIVIDEND_W){din0[DIVIDEND_W-1]}}, din0};
    assign din1_x   = {din1[DIVISOR_W-1], din1};
    assign din0_mag = din0_x[MW-1] ? -din0_x : din0_x;
    assign din1_mag = din1_x[DIVISOR_W] ? -din1_x : din1_x;

    assign dvs_ext = MW'(dvs_mag);
    assign shl     = MW'({prem, dvd_mag[cnt]});
    assign diff    = shl - dvs_ext;
    assign ge      = (shl >= dvs_ext);

    assign in_ready = (state == IDLE);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (in_valid) state_n = (din1 == '0) ? FIX : CALC;
            CALC: if (cnt == '0) state_n = FIX;
            FIX:  state_n = DONE;
            DONE: if (out_valid && out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture and the shift/trial-subtract datapath
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dvd_mag <= '0;
            dvs_mag <= '0;
            neg_dvd <= 1'b0;
            neg_q   <= 1'b0;
            dz      <= 1'b0;
            cnt     <= '0;
            prem    <= '0;
            quot    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_mag <= din0_mag;
                        dvs_mag <= din1_mag;
                        neg_dvd <= din0[DIVIDEND_W-1];
                        neg_q   <= din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
                        dz      <= (din1 == '0);
                        cnt     <= CW'(DIVIDEND_W - 1);
                        prem    <= '0;
                        quot    <= '0;
                    end
                end
                CALC: begin
                    prem <= ge ? diff : shl;
                    quot <= {quot[MW-2:0], ge};
                    cnt  <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers: written once in FIX and held until the next FIX
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            dout     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == FIX) begin
            if (dz) begin
                dout     <= neg_dvd ? QMIN : QMAX;
                rem      <= '0;
                ovf      <= 1'b0;
                div_zero <= 1'b1;
            end else begin
                {ovf, dout} <= sat_quot(neg_q, quot);
                rem         <= sgn_rem(neg_dvd, prem);
                div_zero    <= 1'b0;
            end
        end
    end

    // out_valid rises one cycle after entering DONE and drops on the handshake
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            out_valid <= 1'b0;
        else if (out_valid && out_ready)
            out_valid <= 1'b0;
        else if (state == DONE)
            out_valid <= 1'b1;
    end

endmodule

// File: tb/tb_cnn_div_seq_23s_14s.sv
// Directed and small randomised bench for the sequential 23s/14s divider.
module tb_cnn_div_seq_23s_14s;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [22:0] din0 = '0;
    logic [13:0] din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  dout;
    logic [13:0] rem;
    logic        ovf;
    logic        div_zero;

    int n_cmp = 0;
    int n_err = 0;

    cnn_div_seq_23s_14s dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .rem       (rem),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    always #5 ap_clk = ~ap_clk;

    // Drive one operation, measure latency from acceptance edge, capture result, then consume it.
    task automatic run_op(input int a, input int b, input int hold, output int lat,
                          output int q, output int r, output logic o, output logic z);
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0 = 23'(a);
        din1 = 14'(b);
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge ap_clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        q = int'($signed(dout));
        r = int'($signed(rem));
        o = ovf;
        z = div_zero;
        for (int i = 0; i < hold; i++) @(posedge ap_clk);
        #1 out_ready = 1'b1;
        @(posedge ap_clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, dout, rem, ovf, div_zero} !== {1'b1, 1'b0, 9'd0, 14'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%0b vld=%0b q=%0d r=%0d ovf=%0b dz=%0b want 1 0 0 0 0 0",
                     in_ready, out_valid, dout, rem, ovf, div_zero);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL idle_after_reset: got rdy=%0b vld=%0b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_signs;
        int va[4] = '{-1000, 1000, -1000, 1000};
        int vb[4] = '{7, -7, -7, 7};
        int eq[4] = '{-142, -142, 142, 142};
        int er[4] = '{-6, 6, -6, 6};
        int lat, q, r;
        logic o, z;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], 0, lat, q, r, o, z);
            n_cmp++;
            if (q !== eq[i]) begin
                n_err++;
                $display("FAIL signs_q[%0d]: got %0d want %0d", i, q, eq[i]);
            end
            n_cmp++;
            if (r !== er[i]) begin
                n_err++;
                $display("FAIL signs_rem[%0d]: got %0d want %0d", i, r, er[i]);
            end
            n_cmp++;
            if ({o, z} !== 2'b00) begin
                n_err++;
                $display("FAIL signs_flags[%0d]: got ovf=%0b dz=%0b want 0 0", i, o, z);
            end
            n_cmp++;
            if (lat !== 25) begin
                n_err++;
                $display("FAIL signs_latency[%0d]: got %0d want 25", i, lat);
            end
        end
    endtask

    task automatic test_saturation;
        int va[5] = '{4194303, -4194304, -1792, 1785, 1792};
        int vb[5] = '{1, 1, 7, 7, 7};
        int eq[5] = '{255, -256, -256, 255, 255};
        logic eo[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int lat, q, r;
        logic o, z;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], 0, lat, q, r, o, z);
            n_cmp++;
            if (q !== eq[i]) begin
                n_err++;
                $display("FAIL sat_q[%0d]: got %0d want %0d", i, q, eq[i]);
            end
            n_cmp++;
            if (o !== eo[i]) begin
                n_err++;
                $display("FAIL sat_ovf[%0d]: got %0b want %0b", i, o, eo[i]);
            end
            n_cmp++;
            if (r !== 0) begin
                n_err++;
                $display("FAIL sat_rem[%0d]: got %0d want 0", i, r);
            end
        end
    endtask

    task automatic test_div_zero;
        int va[2] = '{5, -5};
        int eq[2] = '{255, -256};
        int lat, q, r;
        logic o, z;
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], 0, 0, lat, q, r, o, z);
            n_cmp++;
            if (q !== eq[i] || r !== 0) begin
                n_err++;
                $display("FAIL dz_value[%0d]: got q=%0d r=%0d want q=%0d r=0", i, q, r, eq[i]);
            end
            n_cmp++;
            if ({z, o} !== 2'b10) begin
                n_err++;
                $display("FAIL dz_flags[%0d]: got dz=%0b ovf=%0b want 1 0", i, z, o);
            end
            n_cmp++;
            if (lat !== 2) begin
                n_err++;
                $display("FAIL dz_latency[%0d]: got %0d want 2", i, lat);
            end
        end
    endtask

    task automatic test_backpressure;
        logic seen;
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0 = 23'(100);
        din1 = 14'(3);
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge ap_clk); #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (seen !== 1'b1) begin
            n_err++;
            $display("FAIL bp_result_seen: got %0b want 1", seen);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge ap_clk);
            in_valid = c[0];
            din0 = 23'(-50 * c - 7);
            din1 = 14'(c + 1);
            @(posedge ap_clk); #1;
            n_cmp++;
            if ({out_valid, in_ready, dout, rem} !== {1'b1, 1'b0, 9'd33, 14'd1}) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got vld=%0b rdy=%0b q=%0d r=%0d want 1 0 33 1",
                         c, out_valid, in_ready, dout, rem);
            end
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL bp_release: got vld=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (30) begin
            @(posedge ap_clk); #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0 || dout !== 9'd33) begin
            n_err++;
            $display("FAIL bp_ignored_pulses: got busy=%0b q=%0d want 0 33", seen, dout);
        end
    endtask

    task automatic test_reset_mid_calc;
        logic seen;
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0 = 23'(1000);
        din1 = 14'(7);
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge ap_clk);
        #1 ap_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, dout} !== {1'b1, 1'b0, 9'd0}) begin
            n_err++;
            $display("FAIL abort_reset: got rdy=%0b vld=%0b q=%0d want 1 0 0", in_ready, out_valid, dout);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge ap_clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_result: got out_valid seen=%0b want 0", seen);
        end
    endtask

    task automatic test_random;
        logic signed [22:0] ra;
        logic signed [13:0] rb;
        int a, b, eq, er, lat, q, r;
        logic eo, ez, o, z;
        for (int n = 0; n < 250; n++) begin
            ra = 23'($urandom);
            rb = 14'($urandom);
            a = int'(ra) >>> $urandom_range(0, 22);
            b = int'(rb) >>> $urandom_range(0, 13);
            if (b == 0) begin
                eq = (a >= 0) ? 255 : -256;
                er = 0;
                eo = 1'b0;
                ez = 1'b1;
            end else begin
                eq = a / b;
                er = a % b;
                ez = 1'b0;
                eo = (eq > 255) || (eq < -256);
                if (eq > 255) eq = 255;
                if (eq < -256) eq = -256;
            end
            run_op(a, b, $urandom_range(0, 3), lat, q, r, o, z);
            n_cmp++;
            if (q !== eq || r !== er || o !== eo || z !== ez) begin
                n_err++;
                $display("FAIL random %0d/%0d: got q=%0d r=%0d ovf=%0b dz=%0b want q=%0d r=%0d ovf=%0b dz=%0b",
                         a, b, q, r, o, z, eq, er, eo, ez);
            end
        end
    endtask

    initial begin
        test_reset;
        test_signs;
        test_saturation;
        test_div_zero;
        test_backpressure;
        test_reset_mid_calc;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
